// File: rtl/conv_row_scheduler.sv
`default_nettype none
// conv_row_scheduler: round-robin two-requester row feeder for a 1-D conv engine,
// one row in flight, engine timeout and buffered response.  Revision 1.0
module conv_row_scheduler #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  input  logic [255:0] req_row0,
  input  logic [255:0] req_row1,
  output logic [1:0]   req_ready,
  output logic         eng_start,
  output logic [255:0] eng_row,
  input  logic         eng_done,
  input  logic [539:0] eng_result,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic         rsp_err,
  output logic [539:0] rsp_data,
  output logic [15:0]  rows_done
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic           cur_id_q, cur_id_d;
  logic [255:0]   eng_row_q, eng_row_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           rsp_id_q, rsp_id_d;
  logic           rsp_err_q, rsp_err_d;
  logic [539:0]   rsp_data_q, rsp_data_d;
  logic [15:0]    rows_done_q, rows_done_d;

  logic           grant;
  logic           accept;

  // Tie goes to the requester that was not served last; otherwise the lone valid one wins.
  always_comb begin
    grant = 1'b0;
    if (req_valid == 2'b11) begin
      grant = ~last_grant_q;
    end else begin
      grant = ~req_valid[0];
    end
  end

  assign req_ready = (state_q == S_IDLE) ? (req_valid & (grant ? 2'b10 : 2'b01)) : 2'b00;
  assign accept    = |req_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cur_id_d     = cur_id_q;
    eng_row_d    = eng_row_q;
    cnt_d        = cnt_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    rsp_data_d   = rsp_data_q;
    rows_done_d  = rows_done_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d      = S_ISSUE;
          eng_row_d    = grant ? req_row1 : req_row0;
          cur_id_d     = grant;
          last_grant_d = grant;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = 8'd0;
      end
      S_WAIT: begin
        // A done pulse on the final timeout cycle still counts as success.
        if (eng_done) begin
          state_d    = S_RESP;
          rsp_data_d = eng_result;
          rsp_err_d  = 1'b0;
          rsp_id_d   = cur_id_q;
        end else if (cnt_q == TMO_LAST) begin
          state_d    = S_RESP;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          rsp_id_d   = cur_id_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          if (!rsp_err_q && (rows_done_q != 16'hFFFF)) begin
            rows_done_d = rows_done_q + 16'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      cur_id_q     <= 1'b0;
      eng_row_q    <= '0;
      cnt_q        <= 8'd0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_data_q   <= '0;
      rows_done_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cur_id_q     <= cur_id_d;
      eng_row_q    <= eng_row_d;
      cnt_q        <= cnt_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      rsp_data_q   <= rsp_data_d;
      rows_done_q  <= rows_done_d;
    end
  end

  assign eng_start = (state_q == S_ISSUE);
  assign eng_row   = eng_row_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign rows_done = rows_done_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_row_scheduler.sv
`default_nettype none
// Scoreboard bench: directed rows into two scheduler instances (default and short timeout),
// a behavioural [-1,2,-1] engine, and a monitor that checks every accepted response.
module tb_conv_row_scheduler;

  typedef struct packed {
    logic         id;
    logic         err;
    logic [539:0] data;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [1:0]   req_valid;
  logic [255:0] req_row0, req_row1;
  logic         eng_done;
  logic [539:0] eng_result;
  logic         rsp_ready;
  logic         sel;

  logic [1:0]   a_req_ready, b_req_ready, m_req_ready;
  logic         a_eng_start, b_eng_start, m_eng_start;
  logic [255:0] a_eng_row, b_eng_row, m_eng_row;
  logic         a_rsp_valid, b_rsp_valid, m_rsp_valid;
  logic         a_rsp_id, b_rsp_id, m_rsp_id;
  logic         a_rsp_err, b_rsp_err, m_rsp_err;
  logic [539:0] a_rsp_data, b_rsp_data, m_rsp_data;
  logic [15:0]  a_rows_done, b_rows_done, m_rows_done;

  conv_row_scheduler dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_row0(req_row0), .req_row1(req_row1),
    .req_ready(a_req_ready), .eng_start(a_eng_start), .eng_row(a_eng_row),
    .eng_done(eng_done), .eng_result(eng_result), .rsp_valid(a_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(a_rsp_id), .rsp_err(a_rsp_err),
    .rsp_data(a_rsp_data), .rows_done(a_rows_done)
  );

  conv_row_scheduler #(.TIMEOUT_CYCLES(10)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_row0(req_row0), .req_row1(req_row1),
    .req_ready(b_req_ready), .eng_start(b_eng_start), .eng_row(b_eng_row),
    .eng_done(eng_done), .eng_result(eng_result), .rsp_valid(b_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(b_rsp_id), .rsp_err(b_rsp_err),
    .rsp_data(b_rsp_data), .rows_done(b_rows_done)
  );

  assign m_req_ready = sel ? b_req_ready : a_req_ready;
  assign m_eng_start = sel ? b_eng_start : a_eng_start;
  assign m_eng_row   = sel ? b_eng_row   : a_eng_row;
  assign m_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign m_rsp_id    = sel ? b_rsp_id    : a_rsp_id;
  assign m_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
  assign m_rsp_data  = sel ? b_rsp_data  : a_rsp_data;
  assign m_rows_done = sel ? b_rows_done : a_rows_done;

  rsp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   start_cnt = 0;
  bit   eng_on;
  int   eng_lat;
  int   stray_cnt = 0;
  int   stray_seen = 0;
  rsp_t mon_e;

  function automatic logic [539:0] conv3(input logic [255:0] row);
    logic [539:0] r;
    int v;
    r = '0;
    for (int j = 0; j < 30; j++) begin
      v = -int'(row[8*j +: 8]) + 2 * int'(row[8*(j+1) +: 8]) - int'(row[8*(j+2) +: 8]);
      r[18*j +: 18] = 18'(v);
    end
    return r;
  endfunction

  function automatic logic [255:0] mkrow(input int a, input int b);
    logic [255:0] r;
    for (int k = 0; k < 32; k++) r[8*k +: 8] = 8'((a * k + b) & 255);
    return r;
  endfunction

  task automatic chk(input string name, input logic [539:0] act, input logic [539:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic id, input logic err, input logic [539:0] data);
    rsp_t e;
    e.id = id; e.err = err; e.data = data;
    sb_q.push_back(e);
  endtask

  // Response monitor and per-cycle protocol checks.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_eng_start) start_cnt++;
      chk("ready_both_high", 540'(&m_req_ready), 540'(0));
      if (m_rsp_valid) chk("ready_during_resp", 540'(m_req_ready), 540'(0));
      if (m_rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rsp: got id %0d err %0d, expected no response", m_rsp_id, m_rsp_err);
        end else begin
          mon_e = sb_q.pop_front();
          chk("rsp_id", 540'(m_rsp_id), 540'(mon_e.id));
          chk("rsp_err", 540'(m_rsp_err), 540'(mon_e.err));
          chk("rsp_data", m_rsp_data, mon_e.data);
        end
      end
    end
  end

  // Engine model: [-1,2,-1] valid convolution delivered eng_lat cycles after start.
  initial begin
    logic [539:0] res;
    eng_done = 1'b0;
    eng_result = '0;
    forever begin
      @(negedge clk);
      if (stray_cnt != stray_seen) begin
        stray_seen = stray_cnt;
        eng_done = 1'b1;
        eng_result = {135{4'h5}};
        @(negedge clk);
        eng_done = 1'b0;
        eng_result = '0;
      end else if (m_eng_start && eng_on && !rst) begin
        res = conv3(m_eng_row);
        repeat (eng_lat) @(posedge clk);
        #1;
        eng_done = 1'b1;
        eng_result = res;
        @(posedge clk);
        #1;
        eng_done = 1'b0;
        eng_result = '0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_accept(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (m_req_ready == 2'b00 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_accept: got no req_ready within 50 cycles, expected a grant", name);
    end
    tick(1);
  endtask

  task automatic wait_drain(input string name, input int bound);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < bound) begin
      @(posedge clk);
      t++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_drain: got %0d responses pending, expected 0", name, sb_q.size());
      sb_q.delete();
    end
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    chk({tag, "_rsp_valid"}, 540'(m_rsp_valid), 540'(0));
    chk({tag, "_eng_start"}, 540'(m_eng_start), 540'(0));
    chk({tag, "_eng_row"},   540'(m_eng_row),   540'(0));
    chk({tag, "_rsp_data"},  m_rsp_data,        540'(0));
    chk({tag, "_rsp_id"},    540'(m_rsp_id),    540'(0));
    chk({tag, "_rsp_err"},   540'(m_rsp_err),   540'(0));
    chk({tag, "_rows_done"}, 540'(m_rows_done), 540'(0));
    chk({tag, "_req_ready"}, 540'(m_req_ready), 540'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] ramp, row_a, row_b, row_c, row_d;
    int s0, t;
    ramp  = mkrow(1, 0);
    row_a = mkrow(37, 5);
    row_b = mkrow(-3, 200);
    row_c = mkrow(11, 90);
    row_d = mkrow(5, 250);

    rst = 1'b1; req_valid = 2'b00; req_row0 = '0; req_row1 = '0;
    rsp_ready = 1'b1; sel = 1'b0; eng_on = 1'b1; eng_lat = 67;
    tick(3);
    rst = 1'b0;
    check_reset_vals("reset");

    // Single row from requester 0, ramp pixels.
    tick(1);
    s0 = start_cnt;
    req_row0 = ramp;
    push(1'b0, 1'b0, conv3(ramp));
    req_valid = 2'b01;
    wait_accept("single");
    req_valid = 2'b00;
    wait_drain("single", 300);
    @(negedge clk);
    chk("single_rows_done", 540'(m_rows_done), 540'(1));
    chk("single_start_pulses", 540'(start_cnt - s0), 540'(1));

    // Contention: both requesters held valid for four rows.
    tick(1);
    do_reset();
    req_row0 = row_a;
    req_row1 = row_b;
    push(1'b0, 1'b0, conv3(row_a));
    push(1'b1, 1'b0, conv3(row_b));
    push(1'b0, 1'b0, conv3(row_a));
    push(1'b1, 1'b0, conv3(row_b));
    req_valid = 2'b11;
    wait_drain("contend", 600);
    req_valid = 2'b00;
    @(negedge clk);
    chk("contend_rows_done", 540'(m_rows_done), 540'(4));

    // Backpressure: response held 20 cycles while both requesters wait.
    tick(1);
    req_row0 = row_c;
    rsp_ready = 1'b0;
    push(1'b0, 1'b0, conv3(row_c));
    req_valid = 2'b01;
    wait_accept("bp");
    req_valid = 2'b11;
    t = 0;
    @(negedge clk);
    while (!m_rsp_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("bp_rsp_arrived", 540'(m_rsp_valid), 540'(1));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 540'(m_rsp_valid), 540'(1));
      chk("bp_rsp_data", m_rsp_data, conv3(row_c));
      chk("bp_eng_row", 540'(m_eng_row), 540'(row_c));
      chk("bp_req_ready", 540'(m_req_ready), 540'(0));
    end
    tick(1);
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    wait_drain("bp", 5);
    @(negedge clk);
    chk("bp_rows_done", 540'(m_rows_done), 540'(5));
    chk("bp_eng_row_after", 540'(m_eng_row), 540'(row_c));
    chk("bp_rsp_data_after", m_rsp_data, conv3(row_c));

    // Timeout on the 10-cycle instance with a silent engine.
    tick(1);
    sel = 1'b1;
    eng_on = 1'b0;
    do_reset();
    req_row0 = row_d;
    push(1'b0, 1'b1, 540'(0));
    req_valid = 2'b01;
    wait_accept("tmo");
    req_valid = 2'b00;
    t = 0;
    @(negedge clk);
    while (!m_eng_start && t < 10) begin
      @(negedge clk);
      t++;
    end
    t = 0;
    while (!m_rsp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("tmo_latency", 540'(t), 540'(11));
    wait_drain("tmo", 10);
    @(negedge clk);
    chk("tmo_rows_done", 540'(m_rows_done), 540'(0));

    // Done arriving on the last timeout cycle wins.
    tick(1);
    eng_on = 1'b1;
    eng_lat = 10;
    req_row1 = row_a;
    push(1'b1, 1'b0, conv3(row_a));
    req_valid = 2'b10;
    wait_accept("edge");
    req_valid = 2'b00;
    wait_drain("edge", 60);
    @(negedge clk);
    chk("edge_rows_done", 540'(m_rows_done), 540'(1));

    // Reset during WAIT, then a stray done pulse.
    tick(1);
    sel = 1'b0;
    eng_on = 1'b0;
    do_reset();
    req_row0 = row_b;
    req_valid = 2'b01;
    wait_accept("abort");
    req_valid = 2'b00;
    tick(30);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    stray_cnt = stray_cnt + 1;
    tick(4);
    check_reset_vals("abort");
    tick(1);
    req_row1 = row_c;
    req_valid = 2'b11;
    @(negedge clk);
    chk("abort_next_grant", 540'(m_req_ready), 540'(2'b01));
    push(1'b0, 1'b1, 540'(0));
    tick(1);
    req_valid = 2'b00;
    wait_drain("abort", 400);
    @(negedge clk);
    chk("abort_rows_done", 540'(m_rows_done), 540'(0));

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
